// File: rtl/byte_serial_addsub.sv
// Byte-serial 32-bit adder/subtractor: one byte per cycle, LSB first, then streams the result out.
// Optional saturation signalling is built when BYTE_SERIAL_ADDSUB_SAT_EN is defined.
module byte_serial_addsub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        sat_enable,
  output logic        sat_sign,
  output logic        sat_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, EMIT = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sub;
  logic        r_carry;
  logic [1:0]  r_idx;
  logic [31:0] r_res;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [7:0]  r_out_byte;
  logic        r_out_last;

  logic [7:0]  w_a_byte;
  logic [7:0]  w_b_byte;
  logic [8:0]  w_sum;
  logic [1:0]  w_nidx;
  logic        w_accept;
  logic        w_calc_done;
  logic        w_emit_take;
  logic        w_emit_last;

  // Byte slice adder; subtraction is A + ~B with the initial carry set to 1.
  always_comb begin
    w_a_byte    = r_a[{r_idx, 3'b000} +: 8];
    w_b_byte    = r_sub ? ~r_b[{r_idx, 3'b000} +: 8] : r_b[{r_idx, 3'b000} +: 8];
    w_sum       = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'd0, r_carry};
    w_nidx      = r_idx + 2'd1;
    w_accept    = (r_state == IDLE) && in_valid && r_in_ready;
    w_calc_done = (r_state == CALC) && (r_idx == 2'd3);
    w_emit_take = (r_state == EMIT) && r_out_valid && out_ready;
    w_emit_last = w_emit_take && (r_idx == 2'd3);
  end

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= 2'd0;
      r_res       <= 32'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_sub      <= sub;
            r_carry    <= sub;
            r_idx      <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_res[{r_idx, 3'b000} +: 8] <= w_sum[7:0];
          r_carry <= w_sum[8];
          r_idx   <= w_nidx;
          // Byte 0 was stored three cycles ago, so it can be presented now.
          if (r_idx == 2'd3) begin
            r_state     <= EMIT;
            r_out_valid <= 1'b1;
            r_out_byte  <= r_res[7:0];
            r_out_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (w_emit_last) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_idx       <= 2'd0;
          end else if (w_emit_take) begin
            r_idx      <= w_nidx;
            r_out_byte <= r_res[{w_nidx, 3'b000} +: 8];
            r_out_last <= (w_nidx == 2'd3);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;

`ifdef BYTE_SERIAL_ADDSUB_SAT_EN
  logic       r_signed;
  logic       r_ovf;
  logic       r_neg;
  logic       r_sat_enable;
  logic       r_sat_sign;
  logic       r_sat_last;
  logic [7:0] w_low7;
  logic       w_ovf;
  logic       w_neg;

  // Overflow from the top byte: carry into bit 31 comes from the low 7 bits of that byte.
  always_comb begin
    w_low7 = {1'b0, w_a_byte[6:0]} + {1'b0, w_b_byte[6:0]} + {7'd0, r_carry};
    w_ovf  = r_signed ? (w_low7[7] ^ w_sum[8]) : (r_sub ? ~w_sum[8] : w_sum[8]);
    w_neg  = r_signed ? r_a[31] : r_sub;
  end

  // Saturation flags, updated in lockstep with the main FSM transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed     <= 1'b0;
      r_ovf        <= 1'b0;
      r_neg        <= 1'b0;
      r_sat_enable <= 1'b0;
      r_sat_sign   <= 1'b0;
      r_sat_last   <= 1'b0;
    end else if (w_accept) begin
      r_signed <= is_signed;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_calc_done) begin
      r_ovf        <= w_ovf;
      r_neg        <= w_neg;
      r_sat_enable <= w_ovf;
      r_sat_sign   <= w_neg;
      r_sat_last   <= 1'b0;
    end else if (w_emit_last) begin
      r_sat_enable <= 1'b0;
      r_sat_sign   <= 1'b0;
      r_sat_last   <= 1'b0;
    end else if (w_emit_take) begin
      r_sat_enable <= r_ovf;
      r_sat_sign   <= r_neg;
      r_sat_last   <= r_signed && (w_nidx == 2'd3);
    end else begin
      r_sat_last <= r_sat_last;
    end
  end

  assign sat_enable = r_sat_enable;
  assign sat_sign   = r_sat_sign;
  assign sat_last   = r_sat_last;
`else
  logic w_unused;
  assign w_unused   = is_signed;
  assign sat_enable = 1'b0;
  assign sat_sign   = 1'b0;
  assign sat_last   = 1'b0;
`endif

endmodule

// File: tb/tb_byte_serial_addsub.sv
// Randomised and directed bench for byte_serial_addsub against a plain-arithmetic reference model.
module tb_byte_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        sub = 1'b0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        sat_enable;
  logic        sat_sign;
  logic        sat_last;

  int n_vec = 0;
  int n_err = 0;

  byte_serial_addsub dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .sat_enable(sat_enable), .sat_sign(sat_sign), .sat_last(sat_last)
  );

  always #5 clk = ~clk;

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input logic sg);
    longint r;
    if (sg) begin
      r = s ? (longint'($signed(x)) - longint'($signed(y)))
            : (longint'($signed(x)) + longint'($signed(y)));
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end else begin
      r = s ? (longint'({32'd0, x}) - longint'({32'd0, y}))
            : (longint'({32'd0, x}) + longint'({32'd0, y}));
      return (r > 64'sd4294967295) || (r < 64'sd0);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // stall_k: byte on which out_ready is held low for stall_n cycles; abort_k: byte at which to stop.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic tsg, input int stall_k, input int stall_n, input int abort_k);
    logic [31:0] res;
    logic        ovf;
    logic        neg;
    logic        e_en;
    logic        e_sg;
    logic        e_ls;
    res = ts ? (ta - tb) : (ta + tb);
    ovf = ref_ovf(ta, tb, ts, tsg);
    neg = tsg ? ta[31] : ts;
    wait_ready();
    a = ta; b = tb; sub = ts; is_signed = tsg; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = $urandom; b = $urandom; sub = $urandom_range(1, 0) == 1; is_signed = ~tsg;
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    chk("calc_valid_e0", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("calc_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
`ifdef BYTE_SERIAL_ADDSUB_SAT_EN
      e_en = ovf; e_sg = neg; e_ls = tsg && (k == 3);
`else
      e_en = 1'b0; e_sg = 1'b0; e_ls = 1'b0;
`endif
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_byte", {24'd0, out_byte}, {24'd0, res[8*k +: 8]});
      chk("out_last", {31'd0, out_last}, {31'd0, (k == 3)});
      chk("sat_enable", {31'd0, sat_enable}, {31'd0, e_en});
      chk("sat_sign", {31'd0, sat_sign}, {31'd0, e_sg});
      chk("sat_last", {31'd0, sat_last}, {31'd0, e_ls});
      chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
      if (k == abort_k) return;
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("stall_byte", {24'd0, out_byte}, {24'd0, res[8*k +: 8]});
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_sat", {29'd0, sat_enable, sat_sign, sat_last}, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, -1, 0, 4);
    run_op(32'hFFFFFFF0, 32'h00000020, 1'b0, 1'b0, -1, 0, 4);
    run_op(32'h00000005, 32'h00000006, 1'b1, 1'b0, -1, 0, 4);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, -1, 0, 4);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, -1, 0, 4);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1, 3, 4);
    run_op(32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, -1, 0, 1);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, -1, 0, 4);
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
             $urandom_range(3, 0), $urandom_range(3, 0), 4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
